// File: rtl/p_codec_pkg.sv
// Shared types for the leading-one codec pair (priority encoder and
// its sequential inverse, the bitmask-rebuilding decoder).
package p_codec_pkg;

    localparam int P_WIDTH = 16;
    localparam int P_IDX_W = 4;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } dec_state_t;

    typedef logic [P_WIDTH-1:0] bitmask_t;
    typedef logic [P_IDX_W-1:0] idx_t;

endpackage

// File: rtl/p_decoder_4to16.sv
// Combinational MSB-first index decoder: index 0 selects the top bit,
// index WIDTH-1 selects bit 0. A zero-flagged beat decodes to no bits.
module p_decoder_4to16
    import p_codec_pkg::*;
#(
    parameter  int WIDTH = P_WIDTH,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             is_zero,
    output logic [WIDTH-1:0] onehot
);

    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

    // Shifting the top bit right by idx lands on bit WIDTH-1-idx.
    always_comb begin
        onehot = '0;
        if (!is_zero) begin
            onehot = MSB_ONE >> idx;
        end
    end

endmodule

// File: rtl/p_decoder_4to16_acc.sv
// Rebuilds a bitmask from a stream of leading-one index beats. Beats are
// OR-accumulated until a last-flagged beat, then the mask, non-zero beat
// count and repeat flag are presented on a valid/ready output. A new mask
// may start in the same cycle the previous one is taken.
module p_decoder_4to16_acc
    import p_codec_pkg::*;
#(
    parameter  int WIDTH = P_WIDTH,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_is_zero,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bitmask,
    output logic [IDX_W:0]   out_count,
    output logic             out_dup
);

    localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(WIDTH);

    dec_state_t       state;
    dec_state_t       state_nxt;
    logic [WIDTH-1:0] acc_mask;
    logic [IDX_W:0]   acc_count;
    logic             acc_dup;
    logic [WIDTH-1:0] onehot;
    logic [WIDTH-1:0] mask_nxt;
    logic [IDX_W:0]   count_nxt;
    logic             dup_nxt;
    logic             beat_fire;

    // Count only grows past WIDTH when indices repeat; hold it at WIDTH.
    function automatic logic [IDX_W:0] sat_inc(input logic [IDX_W:0] c);
        if (c == CNT_MAX) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    p_decoder_4to16 #(
        .WIDTH (WIDTH)
    ) u_dec (
        .idx     (in_idx),
        .is_zero (in_is_zero),
        .onehot  (onehot)
    );

    // In DONE the decoder only takes a beat when the held result is being
    // consumed in the same cycle, so the output is never overwritten early.
    assign in_ready  = (state == ACCUM) || out_ready;
    assign out_valid = (state == DONE);
    assign beat_fire = in_valid && in_ready;

    // Next state plus the accumulator values including the current beat.
    always_comb begin
        state_nxt = state;
        mask_nxt  = acc_mask | onehot;
        count_nxt = in_is_zero ? acc_count : sat_inc(acc_count);
        dup_nxt   = acc_dup | (|(acc_mask & onehot));
        case (state)
            ACCUM: begin
                if (beat_fire && in_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready && !(beat_fire && in_last)) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Accumulators clear on the last beat so the next beat starts fresh;
    // output registers load only on the last beat and otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_mask    <= '0;
            acc_count   <= '0;
            acc_dup     <= 1'b0;
            out_bitmask <= '0;
            out_count   <= '0;
            out_dup     <= 1'b0;
        end else if (beat_fire) begin
            if (in_last) begin
                acc_mask    <= '0;
                acc_count   <= '0;
                acc_dup     <= 1'b0;
                out_bitmask <= mask_nxt;
                out_count   <= count_nxt;
                out_dup     <= dup_nxt;
            end else begin
                acc_mask  <= mask_nxt;
                acc_count <= count_nxt;
                acc_dup   <= dup_nxt;
            end
        end
    end

endmodule

// File: tb/tb_p_decoder_4to16_acc.sv
// Bench for the index-stream bitmask decoder: directed scenarios followed
// by random masks split into leading-one beats, with a queue of expected
// results consumed at every output handshake.
module tb_p_decoder_4to16_acc;
    import p_codec_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_idx = '0;
    logic       in_is_zero = 1'b0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    bitmask_t   out_bitmask;
    logic [4:0] out_count;
    logic       out_dup;

    typedef struct {
        logic [15:0] mask;
        logic [4:0]  count;
        logic        dup;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    p_decoder_4to16_acc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_idx      (in_idx),
        .in_is_zero  (in_is_zero),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bitmask (out_bitmask),
        .out_count   (out_count),
        .out_dup     (out_dup)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [15:0] m, input int c, input bit d);
        exp_t e;
        e.mask  = m;
        e.count = 5'(c);
        e.dup   = d;
        exp_q.push_back(e);
    endtask

    // Every accepted output is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_bitmask", 32'(out_bitmask), 32'(e.mask));
                check("out_count", 32'(out_count), 32'(e.count));
                check("out_dup", 32'(out_dup), 32'(e.dup));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input int idx, input bit zero, input bit last, input bit rnd);
        int  waitc = 0;
        bit  taken = 1'b0;
        in_valid   = 1'b1;
        in_idx     = 4'(idx);
        in_is_zero = zero;
        in_last    = last;
        while (!taken) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            taken = in_ready;
            tick();
            waitc++;
            if (!taken && waitc > 200) begin
                check("beat_timeout", 32'd0, 32'd1);
                taken = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Split src into leading-one indices the way the encoder does, add
    // ndup repeated indices and maybe a zero beat, shuffle, and send.
    task automatic run_mask(input logic [15:0] src, input int ndup, input bit rnd);
        int idxs[$];
        int cnt;
        for (int b = 15; b >= 0; b--) begin
            if (src[b]) idxs.push_back(15 - b);
        end
        cnt = $countones(src);
        if (src != 0) begin
            for (int d = 0; d < ndup; d++) begin
                idxs.push_back(idxs[$urandom_range(0, idxs.size() - 1)]);
            end
            cnt = cnt + ndup;
            if (rnd && $urandom_range(0, 3) == 0) idxs.push_back(-1);
        end else begin
            idxs.push_back(-1);
        end
        for (int i = idxs.size() - 1; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(0, i);
            t = idxs[i];
            idxs[i] = idxs[j];
            idxs[j] = t;
        end
        if (cnt > 16) cnt = 16;
        push_exp(src, cnt, (src != 0) && (ndup > 0));
        for (int i = 0; i < idxs.size(); i++) begin
            if (rnd) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            if (idxs[i] < 0) begin
                send_beat(int'($urandom_range(0, 15)), 1'b1, i == idxs.size() - 1, rnd);
            end else begin
                send_beat(idxs[i], 1'b0, i == idxs.size() - 1, rnd);
            end
        end
        check("rnd_lat_valid", 32'(out_valid), 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_bitmask", 32'(out_bitmask), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_dup", 32'(out_dup), 32'd0);

        // Reset mid-mask discards the partial accumulation.
        send_beat(0, 1'b0, 1'b0, 1'b0);
        send_beat(5, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        push_exp(16'h0001, 1, 1'b0);
        send_beat(15, 1'b0, 1'b1, 1'b0);
        check("midrst_lat_valid", 32'(out_valid), 32'd1);
        check("midrst_bitmask", 32'(out_bitmask), 32'h0001);
        out_ready = 1'b1;
        tick();

        // Three ascending-position beats.
        push_exp(16'h9001, 3, 1'b0);
        send_beat(0, 1'b0, 1'b0, 1'b0);
        send_beat(3, 1'b0, 1'b0, 1'b0);
        send_beat(15, 1'b0, 1'b1, 1'b0);
        check("three_lat_valid", 32'(out_valid), 32'd1);
        tick();

        // Repeated index then a zero-flagged last beat.
        push_exp(16'h2000, 2, 1'b1);
        send_beat(2, 1'b0, 1'b0, 1'b0);
        send_beat(2, 1'b0, 1'b0, 1'b0);
        send_beat(9, 1'b1, 1'b1, 1'b0);
        tick();

        // Backpressure: result held, new beat refused.
        out_ready = 1'b0;
        push_exp(16'h0100, 1, 1'b0);
        send_beat(7, 1'b0, 1'b1, 1'b0);
        in_valid   = 1'b1;
        in_idx     = 4'd3;
        in_is_zero = 1'b0;
        in_last    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_bitmask", 32'(out_bitmask), 32'h0100);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_keep", 32'(out_bitmask), 32'h0100);

        // Back-to-back single-beat masks, one per cycle.
        push_exp(16'h8000, 1, 1'b0);
        push_exp(16'h4000, 1, 1'b0);
        push_exp(16'h2000, 1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            send_beat(k, 1'b0, 1'b1, 1'b0);
            check("b2b_valid", 32'(out_valid), 32'd1);
        end
        tick();

        // Boundary masks: empty, full, and full with repeats (count saturates).
        run_mask(16'h0000, 0, 1'b0);
        run_mask(16'hFFFF, 0, 1'b0);
        run_mask(16'hFFFF, 2, 1'b0);

        // Random round trip with random gaps and consumer stalls.
        for (int n = 0; n < 60; n++) begin
            run_mask(16'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b1);
        end

        out_ready = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
        check("drain_left", 32'(exp_q.size()), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/p_decoder_4to16_acc.md
Name: p_decoder_4to16_acc

Overview:
Sequential inverse of the 16-to-4 MSB-first priority encoder used in the bit-serial datapath. It accepts a stream of 4-bit leading-one indices, one per beat, each with its zero flag. It rebuilds the 16-bit bitmask those indices describe by accumulating one-hot decodes until a last-flagged beat. It then holds the mask, beat count and duplicate flag on a valid/ready output until the consumer takes them. It sits between the essential-bit index stream and the PE operand register file.

Parameters:
- WIDTH, 16, bitmask width; must be a power of two, at least 2.
- IDX_W, $clog2(WIDTH), index width (4 at default). Derived; not overridden independently.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, index beat valid.
- in_ready, output, 1, decoder can accept a beat.
- in_idx, input, IDX_W, leading-one index; 0 selects bit WIDTH-1, WIDTH-1 selects bit 0.
- in_is_zero, input, 1, beat carries no set bit; in_idx is ignored.
- in_last, input, 1, final beat of the current mask.
- out_valid, output, 1, reconstructed mask available.
- out_ready, input, 1, consumer accepts the mask.
- out_bitmask, output, WIDTH, reconstructed bitmask.
- out_count, output, IDX_W+1, number of non-zero beats accumulated.
- out_dup, output, 1, some non-zero index repeated within the mask.

Behaviour:
- Decode mapping: bit position = WIDTH-1-in_idx. This is the exact inverse of the encoder convention.
- Handshakes:
  - A beat transfers when in_valid && in_ready.
  - An output transfers when out_valid && out_ready.
  - Inputs (in_idx, in_is_zero, in_last) must hold stable while in_valid=1 && in_ready=0.
- States (FSM):
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: out_valid=1, in_ready=out_ready.
- Reset (asynchronous, any time, including mid-mask):
  - state=ACCUM; acc_mask, acc_count, acc_dup = 0.
  - out_valid=0, out_bitmask=0, out_count=0, out_dup=0, in_ready=1 after reset release.
  - Any partial accumulation is discarded.
- ACCUM, beat accepted with in_is_zero=0:
  - acc_mask |= onehot.
  - acc_count += 1, saturating at WIDTH.
  - acc_dup |= (acc_mask & onehot) != 0.
- ACCUM, beat accepted with in_is_zero=1: acc_mask and acc_count unchanged.
- ACCUM, beat accepted with in_last=1:
  - Output registers load the final values, including the current beat's contribution.
  - Go to DONE next cycle.
  - Accumulators clear to 0.
  - Latency: last beat accepted at edge N gives out_valid=1 after edge N, so the value is visible in cycle N+1.
- Single-beat mask: a beat with in_last=1 from a cleared accumulator is legal. A zero-flagged single beat yields mask 0, count 0.
- DONE:
  - Outputs are held stable while out_ready=0; in_ready=0 (backpressure).
- DONE, out_ready=1 with no beat: go to ACCUM; out_valid drops next cycle. Output data registers keep their last values and are not cleared.
- DONE, out_ready=1 with a beat accepted in the same cycle:
  - The beat starts a fresh mask from zero; no bubble.
  - If that beat also has in_last=1, stay in DONE with new outputs loaded (back-to-back throughput of one mask per cycle).
- Arithmetic: out_count is IDX_W+1 bits so a full WIDTH count fits. The saturation guard applies only when duplicates push the beat count past WIDTH.
- Ordering: indices are not required to be ascending. Any order gives the same mask; only out_dup reflects repeats.

Decomposition:
- Package p_codec_pkg:
  - localparams P_WIDTH=16 and P_IDX_W=4.
  - typedef enum logic [0:0] {ACCUM, DONE} dec_state_t.
  - typedefs bitmask_t and idx_t.
  - The encoder re-uses these types.
- Sub-module p_decoder_4to16: purely combinational. Maps idx and is_zero to a one-hot, using the MSB-first mapping; all-zero output when is_zero=1.
- The top contains the FSM, accumulators and output registers.

Test Plan:
- Reset mid-mask: accept idx 0 and idx 5 without last, then assert rst_n=0 for one cycle → after release out_valid=0, in_ready=1. Next single beat idx 15 with last gives out_bitmask=16'h0001, count=1.
- Three beats idx 0, 3, 15 (last on 15), out_ready=1 → one cycle later out_valid=1, out_bitmask=16'h9001, out_count=3, out_dup=0.
- Duplicates plus zero beat: idx 2, idx 2, then is_zero with last → out_bitmask=16'h2000, out_count=2, out_dup=1.
- Backpressure: complete mask idx 7 (last), hold out_ready=0 for 4 cycles → out_bitmask=16'h0100 stable, in_ready=0, offered beats not consumed. Raise out_ready → out_valid falls next cycle.
- Back-to-back single-beat masks idx 0, 1, 2 (each last), out_ready=1 → out_valid high for 3 consecutive cycles with 16'h8000, 16'h4000, 16'h2000.
- Round trip: random 16-bit masks decomposed into leading-one indices by the encoder model (strip MSB each beat), random in_valid/out_ready gaps → every out_bitmask equals the source mask, and out_count equals its popcount.
